// File: rtl/scoreboard_params.sv
// Shared types for the register scoreboard: register address and the
// issue/event records that decode and the pipeline present each cycle.
package scoreboard_params;
  localparam int ADDRESS_BITS = 5;

  typedef logic [ADDRESS_BITS-1:0] RegisterAddress;

  typedef struct packed {
    logic           write_enabled;
    RegisterAddress write_register;
    logic           result_late;
  } ScoreboardIssueRequest;

  typedef struct packed {
    logic           valid;
    RegisterAddress register_address;
  } ScoreboardEvent;
endpackage

// File: rtl/register_scoreboard_if.sv
// Decode/pipeline <-> scoreboard signal bundle. The master side is the
// pipeline (drives issue/ready/retire/flush); the slave side is the scoreboard.
interface register_scoreboard_if #(
  parameter int REGISTER_COUNT = 32,
  parameter int ADDRESS_WIDTH  = 5,
  parameter int READ_PORTS     = 2
);
  logic [READ_PORTS*ADDRESS_WIDTH-1:0] read_register;
  logic [READ_PORTS-1:0]               read_used;
  logic                                issue_valid;
  logic                                issue_write_enabled;
  logic [ADDRESS_WIDTH-1:0]            issue_write_register;
  logic                                issue_result_late;
  logic                                issue_ready;
  logic [READ_PORTS-1:0]               read_stall;
  logic                                ready_valid;
  logic [ADDRESS_WIDTH-1:0]            ready_register;
  logic                                retire_valid;
  logic [ADDRESS_WIDTH-1:0]            retire_register;
  logic                                flush;
  logic [REGISTER_COUNT-1:0]           pending_mask;
  logic [REGISTER_COUNT-1:0]           late_mask;
  logic                                underflow_error;

  modport master (
    output read_register, read_used, issue_valid, issue_write_enabled,
           issue_write_register, issue_result_late, ready_valid, ready_register,
           retire_valid, retire_register, flush,
    input  issue_ready, read_stall, pending_mask, late_mask, underflow_error
  );

  modport slave (
    input  read_register, read_used, issue_valid, issue_write_enabled,
           issue_write_register, issue_result_late, ready_valid, ready_register,
           retire_valid, retire_register, flush,
    output issue_ready, read_stall, pending_mask, late_mask, underflow_error
  );
endinterface

// File: rtl/scoreboard_counter.sv
// Saturating up/down counter; a decrement from zero (or one vetoed by the
// caller) is dropped and reported on underflow instead of wrapping.
module scoreboard_counter #(
  parameter int MAX_VALUE = 3,
  parameter int WIDTH     = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             increment,
  input  logic             decrement,
  input  logic             decrement_blocked,
  output logic [WIDTH-1:0] count,
  output logic             underflow
);
  logic up, down;

  assign underflow = decrement && (count == '0 || decrement_blocked);
  assign down      = decrement && !underflow;
  // At the ceiling an increment is only allowed when a decrement cancels it.
  assign up        = increment && (count != WIDTH'(MAX_VALUE) || down);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)               count <= '0;
    else if (clear)          count <= '0;
    else if (up && !down)    count <= count + 1'b1;
    else if (down && !up)    count <= count - 1'b1;
  end
endmodule

// File: rtl/register_scoreboard.sv
// Per-register hazard tracker: counts in-flight writes and the subset not yet
// forwardable, and gates issue on late source operands or a full destination.
module register_scoreboard
  import scoreboard_params::*;
#(
  parameter int REGISTER_COUNT = 32,
  parameter int ADDRESS_WIDTH  = ADDRESS_BITS,
  parameter int READ_PORTS     = 2,
  parameter int MAX_PENDING    = 3
) (
  input logic                   clock,
  input logic                   reset,
  register_scoreboard_if.slave  bus
);
  localparam int CW = $clog2(MAX_PENDING + 1);

  logic [REGISTER_COUNT-1:0][CW-1:0] pending_count, late_count;
  logic [REGISTER_COUNT-1:0]         pending_mask, late_mask;
  logic [REGISTER_COUNT-1:0]         pending_under, late_under;
  logic [READ_PORTS-1:0]             stall;
  logic                              dest_full, issue_ready, fire, error_q;

  ScoreboardIssueRequest req;
  ScoreboardEvent        ready_ev, retire_ev;

  assign req       = '{write_enabled:  bus.issue_write_enabled,
                       write_register: bus.issue_write_register,
                       result_late:    bus.issue_result_late};
  assign ready_ev  = '{valid: bus.ready_valid,  register_address: bus.ready_register};
  assign retire_ev = '{valid: bus.retire_valid, register_address: bus.retire_register};

  for (genvar i = 0; i < READ_PORTS; i++) begin : g_port
    logic [ADDRESS_WIDTH-1:0] src;
    assign src      = bus.read_register[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign stall[i] = bus.read_used[i] && src != '0 && late_mask[src];
  end

  // Only registered state feeds issue_ready, so a same-cycle release waits an edge.
  assign dest_full   = req.write_enabled && req.write_register != '0 &&
                       pending_count[req.write_register] == CW'(MAX_PENDING);
  assign issue_ready = !(|stall) && !dest_full;
  assign fire        = bus.issue_valid && issue_ready && req.write_enabled &&
                       req.write_register != '0 && !bus.flush;

  assign pending_count[0] = '0;
  assign late_count[0]    = '0;
  assign pending_under[0] = 1'b0;
  assign late_under[0]    = 1'b0;

  for (genvar r = 1; r < REGISTER_COUNT; r++) begin : g_reg
    logic          hit_issue, hit_ready, hit_retire, late_ok;
    logic [CW:0]   late_after, pend_after;

    assign hit_issue  = fire && req.write_register == ADDRESS_WIDTH'(r);
    assign hit_ready  = ready_ev.valid && !bus.flush &&
                        ready_ev.register_address == ADDRESS_WIDTH'(r);
    assign hit_retire = retire_ev.valid && !bus.flush &&
                        retire_ev.register_address == ADDRESS_WIDTH'(r);
    assign late_ok    = hit_ready && late_count[r] != '0;

    // Net post-edge values decide whether a retire would drop pending below late.
    assign late_after = {1'b0, late_count[r]} + (CW+1)'(hit_issue && req.result_late)
                        - (CW+1)'(late_ok);
    assign pend_after = {1'b0, pending_count[r]} + (CW+1)'(hit_issue) - (CW+1)'(1);

    scoreboard_counter #(.MAX_VALUE(MAX_PENDING), .WIDTH(CW)) u_pending (
      .clock(clock), .reset(reset), .clear(bus.flush),
      .increment(hit_issue), .decrement(hit_retire),
      .decrement_blocked(pend_after < late_after),
      .count(pending_count[r]), .underflow(pending_under[r])
    );

    scoreboard_counter #(.MAX_VALUE(MAX_PENDING), .WIDTH(CW)) u_late (
      .clock(clock), .reset(reset), .clear(bus.flush),
      .increment(hit_issue && req.result_late), .decrement(hit_ready),
      .decrement_blocked(1'b0),
      .count(late_count[r]), .underflow(late_under[r])
    );
  end

  for (genvar r = 0; r < REGISTER_COUNT; r++) begin : g_mask
    assign pending_mask[r] = pending_count[r] != '0;
    assign late_mask[r]    = late_count[r] != '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                 error_q <= 1'b0;
    else if (|{pending_under, late_under})     error_q <= 1'b1;
  end

  assign bus.issue_ready     = issue_ready;
  assign bus.read_stall      = stall;
  assign bus.pending_mask    = pending_mask;
  assign bus.late_mask       = late_mask;
  assign bus.underflow_error = error_q;
endmodule
